// File: rtl/wb_regfile_pkg.sv
// Shared widths, reset constants and the write-back bundle for wb_regfile.
// Mirrors the RegBus/RegAddrBus/ZeroWord/NOPRegAddr values of the core.
package wb_regfile_pkg;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] addr_t;

    localparam word_t ZERO_WORD    = '0;
    localparam addr_t NOP_REG_ADDR = '0;

    typedef struct packed {
        addr_t rw;
        logic  wreg;
        word_t wdata;
    } wb_t;

    localparam wb_t WB_BUBBLE = '{rw: NOP_REG_ADDR, wreg: 1'b0, wdata: ZERO_WORD};

endpackage

// File: rtl/wb_regfile_if.sv
// Execute result, pipeline control, operand read ports and staged result.
// master = execute/decode side, slave = wb_regfile.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic  stall_i;
    logic  flush_i;
    addr_t rw_i;
    logic  wreg_i;
    word_t wdata_i;
    logic  re1_i;
    addr_t raddr1_i;
    logic  re2_i;
    addr_t raddr2_i;
    word_t rdata1_o;
    word_t rdata2_o;
    addr_t wb_rw_o;
    logic  wb_wreg_o;
    word_t wb_wdata_o;

    modport master (
        output stall_i, flush_i, rw_i, wreg_i, wdata_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o, wb_rw_o, wb_wreg_o, wb_wdata_o
    );

    modport slave (
        input  stall_i, flush_i, rw_i, wreg_i, wdata_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o, wb_rw_o, wb_wreg_o, wb_wdata_o
    );

endinterface

// File: rtl/wb_regfile_array.sv
// Register storage: async clear, one write port, two raw read ports.
module wb_regfile_array
    import wb_regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  addr_t waddr,
    input  word_t wdata,
    input  addr_t raddr1,
    input  addr_t raddr2,
    output word_t rdata1,
    output word_t rdata2
);

    word_t mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= ZERO_WORD;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register plus 32-entry register file with two read ports.
// Define WB_BYPASS_EN to forward execute/staged results to the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input logic        clk,
    input logic        rst,
    wb_regfile_if.slave bus
);

    wb_t   st;
    logic  we;
    word_t raw1;
    word_t raw2;
    word_t rd1;
    word_t rd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= WB_BUBBLE;
        end else if (!bus.stall_i) begin
            if (bus.flush_i) begin
                st <= WB_BUBBLE;
            end else begin
                st <= '{rw: bus.rw_i, wreg: bus.wreg_i, wdata: bus.wdata_i};
            end
        end
    end

    // The staged result commits on the same edge it leaves the stage.
    assign we = st.wreg && !bus.stall_i && (st.rw != NOP_REG_ADDR);

    wb_regfile_array u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (st.rw),
        .wdata  (st.wdata),
        .raddr1 (bus.raddr1_i),
        .raddr2 (bus.raddr2_i),
        .rdata1 (raw1),
        .rdata2 (raw2)
    );

`ifdef WB_BYPASS_EN
    logic ex_fwd;
    assign ex_fwd = bus.wreg_i && !bus.flush_i;
`endif

    always_comb begin
        rd1 = raw1;
`ifdef WB_BYPASS_EN
        if (ex_fwd && bus.rw_i == bus.raddr1_i) begin
            rd1 = bus.wdata_i;
        end else if (st.wreg && st.rw == bus.raddr1_i) begin
            rd1 = st.wdata;
        end
`endif
        if (rst || !bus.re1_i || bus.raddr1_i == NOP_REG_ADDR) rd1 = ZERO_WORD;
    end

    always_comb begin
        rd2 = raw2;
`ifdef WB_BYPASS_EN
        if (ex_fwd && bus.rw_i == bus.raddr2_i) begin
            rd2 = bus.wdata_i;
        end else if (st.wreg && st.rw == bus.raddr2_i) begin
            rd2 = st.wdata;
        end
`endif
        if (rst || !bus.re2_i || bus.raddr2_i == NOP_REG_ADDR) rd2 = ZERO_WORD;
    end

    assign bus.rdata1_o   = rd1;
    assign bus.rdata2_o   = rd2;
    assign bus.wb_rw_o    = st.rw;
    assign bus.wb_wreg_o  = st.wreg;
    assign bus.wb_wdata_o = st.wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios then random traffic.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rw;
        logic        wreg;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference: architectural registers plus the one result in flight.
    logic [31:0] m_reg [32];
    logic [4:0]  m_rw;
    logic        m_wreg;
    logic [31:0] m_wd;

    function automatic logic [31:0] m_read(logic re, logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (bus.wreg_i && !bus.flush_i && bus.rw_i == a) return bus.wdata_i;
        if (m_wreg && m_rw == a) return m_wd;
`endif
        return m_reg[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_rw = 5'd0;
        m_wreg = 1'b0;
        m_wd = 32'd0;
    endtask

    task automatic step(input logic r, input logic stall, input logic flush,
                        input logic [4:0] rw, input logic wreg,
                        input logic [31:0] wd,
                        input logic re1, input logic [4:0] a1,
                        input logic re2, input logic [4:0] a2);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.stall_i = stall;
        bus.flush_i = flush;
        bus.rw_i = rw;
        bus.wreg_i = wreg;
        bus.wdata_i = wd;
        bus.re1_i = re1;
        bus.raddr1_i = a1;
        bus.re2_i = re2;
        bus.raddr2_i = a2;
        if (r) m_clear();
        e.r1 = m_read(re1, a1);
        e.r2 = m_read(re2, a2);
        e.rw = m_rw;
        e.wreg = m_wreg;
        e.wd = m_wd;
        exp_q.push_back(e);
        #1 -> sample_ev;
        @(posedge clk);
        if (r) begin
            m_clear();
        end else if (!stall) begin
            if (m_wreg && m_rw != 5'd0) m_reg[m_rw] = m_wd;
            if (flush) begin
                m_rw = 5'd0;
                m_wreg = 1'b0;
                m_wd = 32'd0;
            end else begin
                m_rw = rw;
                m_wreg = wreg;
                m_wd = wd;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got sample expected queued entry");
            end else begin
                e = exp_q.pop_front();
                cmp("rdata1", bus.rdata1_o, e.r1);
                cmp("rdata2", bus.rdata2_o, e.r2);
                cmp("wb_rw", {27'd0, bus.wb_rw_o}, {27'd0, e.rw});
                cmp("wb_wreg", {31'd0, bus.wb_wreg_o}, {31'd0, e.wreg});
                cmp("wb_wdata", bus.wb_wdata_o, e.wd);
            end
        end
    end

    initial begin : driver
        bus.stall_i = 0; bus.flush_i = 0; bus.rw_i = 0; bus.wreg_i = 0;
        bus.wdata_i = 0; bus.re1_i = 0; bus.raddr1_i = 0; bus.re2_i = 0;
        bus.raddr2_i = 0;
        m_clear();

        // reset and basic write to r3
        step(1, 0, 0, 0, 0, 0, 1, 3, 1, 3);
        step(0, 0, 0, 3, 1, 32'h1234_5678, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
        step(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
        step(1, 0, 0, 0, 0, 0, 1, 3, 1, 3);

        // register 0 never holds data
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // stall defers the commit, each result commits once
        step(0, 0, 0, 7, 1, 32'hA5A5_A5A5, 1, 7, 0, 0);
        repeat (3) step(0, 1, 0, 7, 1, 32'h1, 1, 7, 1, 7);
        step(0, 0, 0, 7, 1, 32'h1, 1, 7, 1, 7);
        step(0, 0, 0, 0, 0, 0, 1, 7, 1, 7);
        step(0, 0, 0, 0, 0, 0, 1, 7, 1, 7);

        // flush bubbles execute but staged r5 still commits
        step(0, 0, 0, 5, 1, 32'h55, 1, 5, 1, 4);
        step(0, 0, 1, 4, 1, 32'hDEAD_BEEF, 1, 5, 1, 4);
        step(0, 0, 0, 0, 0, 0, 1, 5, 1, 4);
        // flush with stall: stall wins
        step(0, 0, 0, 6, 1, 32'h66, 1, 6, 0, 0);
        step(0, 1, 1, 8, 1, 32'h88, 1, 6, 1, 8);
        step(0, 0, 0, 0, 0, 0, 1, 6, 1, 8);

        // same-address forwarding candidates on r9
        step(0, 0, 0, 9, 1, 32'h11, 1, 9, 0, 0);
        step(0, 0, 0, 9, 1, 32'h99, 1, 9, 1, 9);
        step(0, 1, 0, 9, 0, 32'h99, 1, 9, 1, 9);
        step(0, 0, 0, 0, 0, 0, 1, 9, 1, 9);

        // dual read of distinct and identical addresses
        step(0, 0, 0, 1, 1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 0, 2, 1, 32'h20, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 2, 1, 2);

        // mid-stall reset discards the staged result
        step(0, 0, 0, 12, 1, 32'hC0C0, 1, 12, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 12, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 12, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 12, 1, 12);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(6) == 0),
                 5'($urandom_range(7)),
                 ($urandom_range(3) != 0),
                 $urandom(),
                 ($urandom_range(5) != 0),
                 5'($urandom_range(7)),
                 ($urandom_range(5) != 0),
                 5'($urandom_range(7)));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
